// File: rtl/fifo_pkg.sv
// Shared sizing constants for the small elastic FIFO and its wrapping pointers.
// Widths are derived from the depth so that non-power-of-two depths size correctly.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int DEPTH_DEF      = 5;
  localparam int PTR_W          = $clog2(DEPTH_DEF);
  localparam int CNT_W          = $clog2(DEPTH_DEF + 1);

  // Pointer width for an arbitrary depth; never narrower than one bit.
  function automatic int ptr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH incrementing pointer with synchronous active-high reset and enable.
// Wraps DEPTH-1 -> 0 explicitly, so DEPTH need not be a power of two.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int P_W   = ptr_bits(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic [P_W-1:0] ptr
);

  localparam logic [P_W-1:0] LAST = P_W'(DEPTH - 1);

  logic [P_W-1:0] ptr_q;
  logic [P_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + P_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/async_fifo_depth5.sv
// Single-clock FIFO (name retained for existing instantiations) with registered read data.
// Occupancy is tracked by an explicit counter; full/empty decode that registered count.
module async_fifo_depth5
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  wclk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int P_W = ptr_bits(DEPTH);
  localparam int C_W = cnt_bits(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [C_W-1:0]        count_q;
  logic [C_W-1:0]        count_d;
  logic [P_W-1:0]        wptr;
  logic [P_W-1:0]        rptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full   = (count_q == C_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  fifo_wrap_ptr #(.DEPTH(DEPTH), .P_W(P_W)) u_wptr (
    .clk   (wclk),
    .reset (reset),
    .en    (wr_acc),
    .ptr   (wptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .P_W(P_W)) u_rptr (
    .clk   (wclk),
    .reset (reset),
    .en    (rd_acc),
    .ptr   (rptr)
  );

  // Storage is never cleared; reset only empties it logically via the count.
  always_comb begin
    mem_d = mem_q;
    if (wr_acc) begin
      mem_d[wptr] = data_in;
    end
  end

  always_ff @(posedge wclk) begin
    mem_q <= mem_d;
  end

  // With 0 < count < DEPTH the pointers differ, so a concurrent write never aliases the read.
  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc) begin
      data_out_d = mem_q[rptr];
    end
  end

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + C_W'(1);
      2'b01:   count_d = count_q - C_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (reset) begin
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_async_fifo_depth5.sv
// Randomised and directed bench for async_fifo_depth5 against a queue-based FIFO model.
module tb_async_fifo_depth5;

  localparam int DW    = 4;
  localparam int DEPTH = 5;

  logic          wclk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned model_q[$];
  logic [DW-1:0] m_dout = '0;

  async_fifo_depth5 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .wclk     (wclk),
    .reset    (reset),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .rd_en    (rd_en),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 wclk = ~wclk;

  // One clock: drive on the falling edge, advance the model at the rising edge, settle 1 time unit.
  task automatic cycle(input logic wr, input int din, input logic rd, input logic rst);
    bit wa, ra;
    @(negedge wclk);
    wr_en   = wr;
    data_in = DW'(din);
    rd_en   = rd;
    reset   = rst;
    @(posedge wclk);
    if (rst) begin
      model_q.delete();
      m_dout = '0;
    end else begin
      wa = wr && (model_q.size() < DEPTH);
      ra = rd && (model_q.size() > 0);
      if (ra) m_dout = DW'(model_q.pop_front());
      if (wa) model_q.push_back(din & ((1 << DW) - 1));
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 7, 1'b1, 1'b1);
    cycle(1'b1, 9, 1'b1, 1'b1);
    n_checks++;
    if ({data_out, full, empty} !== {4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: dout=%0d full=%0b empty=%0b, want dout=0 full=0 empty=1", data_out, full, empty);
    end
    cycle(1'b0, 0, 1'b0, 1'b0);
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dominates_write: empty=%0b, want 1", empty);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i <= 10; i++) begin
      cycle(1'b1, i, 1'b0, 1'b0);
      n_checks++;
      if (full !== (i >= 4) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: full=%0b empty=%0b, want full=%0b empty=0", i, full, empty, (i >= 4));
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 0, 1'b1, 1'b0);
      n_checks++;
      if (data_out !== DW'((i < 5) ? i : 4) || empty !== (i >= 4) || full !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_%0d: dout=%0d empty=%0b full=%0b, want dout=%0d empty=%0b full=0",
                 i, data_out, empty, full, (i < 5) ? i : 4, (i >= 4));
      end
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 11, 1'b0, 1'b0);
    cycle(1'b1, 12, 1'b0, 1'b0);
    cycle(1'b1, 13, 1'b1, 1'b0);
    n_checks++;
    if ({data_out, full, empty} !== {4'd11, 1'b0, 1'b0} || model_q.size() != 2) begin
      n_fail++;
      $display("FAIL simul_rw: dout=%0d full=%0b empty=%0b, want dout=11 full=0 empty=0", data_out, full, empty);
    end
    cycle(1'b0, 0, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 4'd12) begin
      n_fail++;
      $display("FAIL simul_next: dout=%0d, want 12", data_out);
    end
    cycle(1'b0, 0, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 4'd13 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_last: dout=%0d empty=%0b, want dout=13 empty=1", data_out, empty);
    end
  endtask

  task automatic test_wrap();
    int vals[5] = '{12, 1, 6, 7, 8};
    for (int k = 0; k < 12; k++) begin
      int v = $urandom_range(0, 15);
      cycle(1'b1, v, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) cycle(1'b0, 0, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      n_checks++;
      if (data_out !== DW'(v) || data_out !== m_dout) begin
        n_fail++;
        $display("FAIL wrap_pair_%0d: dout=%0d, want %0d", k, data_out, v);
      end
    end
    foreach (vals[i]) cycle(1'b1, vals[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 0, 1'b1, 1'b0);
      n_checks++;
      if (data_out !== DW'(vals[i])) begin
        n_fail++;
        $display("FAIL wrap_order_%0d: dout=%0d, want %0d", i, data_out, vals[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      n_checks++;
      if ({data_out, full, empty} !== {m_dout, model_q.size() == DEPTH, model_q.size() == 0}) begin
        n_fail++;
        $display("FAIL random_%0d: dout=%0d full=%0b empty=%0b, want dout=%0d full=%0b empty=%0b",
                 k, data_out, full, empty, m_dout, model_q.size() == DEPTH, model_q.size() == 0);
      end
    end
  endtask

  task automatic test_mid_reset();
    while (model_q.size() > 0) cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 3, 1'b0, 1'b0);
    cycle(1'b1, 4, 1'b0, 1'b0);
    cycle(1'b1, 5, 1'b1, 1'b0);
    cycle(1'b1, 6, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    n_checks++;
    if ({data_out, full, empty} !== {4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: dout=%0d full=%0b empty=%0b, want dout=0 full=0 empty=1", data_out, full, empty);
    end
    cycle(1'b1, 9, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 4'd9 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_read: dout=%0d empty=%0b, want dout=9 empty=1", data_out, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
